// File: rtl/dram_port_arb.sv
// Two-port arbiter sharing RAM port A between the core data path (port 0) and the
// UART upgrade writer (port 1): round-robin, optional burst lock, upgrade override.
module dram_port_arb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_LEN = 14,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                upgrade_mode_i,
    input  logic                p0_req_i,
    input  logic                p0_lock_i,
    input  logic [ADDR_LEN-1:0] p0_addr_i,
    input  logic [XLEN/8-1:0]   p0_we_i,
    input  logic [XLEN-1:0]     p0_wdata_i,
    output logic                p0_gnt_o,
    output logic                p0_rvalid_o,
    output logic [XLEN-1:0]     p0_rdata_o,
    input  logic                p1_req_i,
    input  logic                p1_lock_i,
    input  logic [ADDR_LEN-1:0] p1_addr_i,
    input  logic [XLEN/8-1:0]   p1_we_i,
    input  logic [XLEN-1:0]     p1_wdata_i,
    output logic                p1_gnt_o,
    output logic                p1_rvalid_o,
    output logic [XLEN-1:0]     p1_rdata_o,
    output logic                ram_en_o,
    output logic [XLEN/8-1:0]   ram_we_o,
    output logic [ADDR_LEN-1:0] ram_addr_o,
    output logic [XLEN-1:0]     ram_wdata_o,
    input  logic [XLEN-1:0]     ram_rd_data_i,
    output logic                busy_o
);

    localparam logic [7:0] LockMaxC = 8'(LOCK_MAX);
    localparam bit         LockEnC  = (LOCK_MAX > 1);

    logic       locked_q, locked_d;
    logic       lock_port_q, lock_port_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       last_win_q, last_win_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic       upg_q;

    logic              lock_eff;
    logic              holder_req;
    logic              win_valid;
    logic              win_port;
    logic              win_lock;
    logic [XLEN/8-1:0] win_we;

    // A rising upgrade_mode drops any held lock immediately.
    assign lock_eff   = locked_q && !(upgrade_mode_i && !upg_q);
    assign holder_req = lock_port_q ? p1_req_i : p0_req_i;

    always_comb begin
        win_valid = 1'b0;
        win_port  = 1'b0;
        if (rst_i) begin
            win_valid = 1'b0;
        end else if (upgrade_mode_i) begin
            win_valid = p1_req_i;
            win_port  = 1'b1;
        end else if (lock_eff && holder_req && (lock_cnt_q < LockMaxC)) begin
            win_valid = 1'b1;
            win_port  = lock_port_q;
        end else if (p0_req_i && p1_req_i) begin
            win_valid = 1'b1;
            win_port  = ~last_win_q;
        end else if (p0_req_i || p1_req_i) begin
            win_valid = 1'b1;
            win_port  = p1_req_i;
        end
    end

    assign win_lock = win_port ? p1_lock_i : p0_lock_i;
    assign win_we   = win_port ? p1_we_i : p0_we_i;

    assign p0_gnt_o    = win_valid && !win_port;
    assign p1_gnt_o    = win_valid && win_port;
    assign ram_en_o    = win_valid;
    assign ram_we_o    = win_valid ? win_we : '0;
    assign ram_addr_o  = p1_gnt_o ? p1_addr_i : p0_addr_i;
    assign ram_wdata_o = p1_gnt_o ? p1_wdata_i : p0_wdata_i;

    assign p0_rvalid_o = rvalid0_q;
    assign p1_rvalid_o = rvalid1_q;
    assign p0_rdata_o  = ram_rd_data_i;
    assign p1_rdata_o  = ram_rd_data_i;
    assign busy_o      = locked_q;

    always_comb begin
        locked_d    = 1'b0;
        lock_port_d = lock_port_q;
        lock_cnt_d  = 8'd0;
        last_win_d  = win_valid ? win_port : last_win_q;
        rvalid0_d   = p0_gnt_o && (p0_we_i == '0);
        rvalid1_d   = p1_gnt_o && (p1_we_i == '0);
        if (win_valid && win_lock && LockEnC) begin
            if (lock_eff && (lock_port_q == win_port)) begin
                // At the cap the holder is granted but released.
                if (lock_cnt_q < LockMaxC) begin
                    locked_d   = 1'b1;
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end else begin
                locked_d    = 1'b1;
                lock_port_d = win_port;
                lock_cnt_d  = 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q    <= 1'b0;
            lock_port_q <= 1'b0;
            lock_cnt_q  <= 8'd0;
            last_win_q  <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            upg_q       <= 1'b0;
        end else begin
            locked_q    <= locked_d;
            lock_port_q <= lock_port_d;
            lock_cnt_q  <= lock_cnt_d;
            last_win_q  <= last_win_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            upg_q       <= upgrade_mode_i;
        end
    end

endmodule
